alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_decode.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and error bit indices for the ALU sequencer
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside rsp_err / sts
    localparam int ERR_OVF = 0;
    localparam int ERR_DBZ = 1;
    localparam int ERR_ILL = 2;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode decode: legality, settle latency, error masks
//
// Ports:
//   cmd     in  4  ALU opcode
//   legal   out 1  opcode is one of add/sub/mul/div/mod
//   latency out 8  settle cycles for the opcode (0 when illegal)
//   ovf_en  out 1  ALU overflow flag is meaningful (add/sub)
//   dbz_en  out 1  ALU divide-by-zero flag is meaningful (div/mod)
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 8
) (
    input  logic [3:0] cmd,
    output logic       legal,
    output logic [7:0] latency,
    output logic       ovf_en,
    output logic       dbz_en
);

    always_comb begin
        legal   = 1'b0;
        latency = 8'd0;
        ovf_en  = 1'b0;
        dbz_en  = 1'b0;
        case (cmd)
            OP_ADD, OP_SUB: begin
                legal   = 1'b1;
                latency = 8'(LAT_ADD);
                ovf_en  = 1'b1;
            end
            OP_MUL: begin
                legal   = 1'b1;
                latency = 8'(LAT_MUL);
            end
            OP_DIV, OP_MOD: begin
                legal   = 1'b1;
                latency = 8'(LAT_DIV);
                dbz_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time front end for the combinational 16-bit ALU
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_cmd, req_a, req_b             opcode and operands
//   req_use_acc                       operand A taken from acc[15:0]
//   rsp_valid/rsp_ready               response handshake
//   rsp_result, rsp_err               captured result, {illegal, dbz, ovf}
//   alu_a, alu_b, alu_cmd             drive to the external ALU
//   alu_result, alu_error             from the external ALU, error = {dbz, ovf}
//   acc                               accumulator, loaded by error-free responses
//   sts_clr, sts                      sticky {illegal, dbz, ovf} and its clear
//   op_count                          completed responses, wrapping
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_use_acc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic [31:0] acc,
    input  logic        sts_clr,
    output logic [2:0]  sts,
    output logic [15:0] op_count
);

    state_t      state;
    logic [7:0]  cnt;
    logic        ovf_en_q;
    logic        dbz_en_q;

    logic        dec_legal;
    logic [7:0]  dec_latency;
    logic        dec_ovf_en;
    logic        dec_dbz_en;
    logic [2:0]  exec_err;

    alu_seq_decode #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) u_decode (
        .cmd     (req_cmd),
        .legal   (dec_legal),
        .latency (dec_latency),
        .ovf_en  (dec_ovf_en),
        .dbz_en  (dec_dbz_en)
    );

    // ALU flags are only trusted for the opcodes that can actually raise them
    always_comb begin
        exec_err          = 3'b000;
        exec_err[ERR_DBZ] = alu_error[1] & dbz_en_q;
        exec_err[ERR_OVF] = alu_error[0] & ovf_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            ovf_en_q   <= 1'b0;
            dbz_en_q   <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= 32'd0;
            rsp_err    <= 3'b000;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_cmd    <= OP_NOP;
            acc        <= 32'd0;
            sts        <= 3'b000;
            op_count   <= 16'd0;
        end else begin
            if (sts_clr) begin
                sts <= 3'b000;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (dec_legal) begin
                            // alu_a/alu_b/alu_cmd are the operand latches themselves
                            alu_a    <= req_use_acc ? acc[15:0] : req_a;
                            alu_b    <= req_b;
                            alu_cmd  <= req_cmd;
                            ovf_en_q <= dec_ovf_en;
                            dbz_en_q <= dec_dbz_en;
                            cnt      <= dec_latency - 8'd1;
                            state    <= EXEC;
                        end else begin
                            // Illegal opcodes never touch the ALU
                            rsp_result        <= 32'd0;
                            rsp_err           <= 3'b000;
                            rsp_err[ERR_ILL]  <= 1'b1;
                            rsp_valid         <= 1'b1;
                            state             <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 8'd0) begin
                        rsp_result <= alu_result;
                        rsp_err    <= exec_err;
                        rsp_valid  <= 1'b1;
                        alu_cmd    <= OP_NOP;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        op_count  <= op_count + 16'd1;
                        if (rsp_err == 3'b000) begin
                            acc <= rsp_result;
                        end
                        // Overrides the clear above: new bits land on a cleared register
                        sts   <= (sts_clr ? 3'b000 : sts) | rsp_err;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_use_acc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_err;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic [31:0] acc;
    logic        sts_clr;
    logic [2:0]  sts;
    logic [15:0] op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_use_acc(req_use_acc),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .acc        (acc),
        .sts_clr    (sts_clr),
        .sts        (sts),
        .op_count   (op_count)
    );

    // External combinational ALU stand-in; error = {dbz, ovf}
    always_comb begin
        logic [15:0] s16;
        s16        = 16'd0;
        alu_result = 32'd0;
        alu_error  = 2'b00;
        case (alu_cmd)
            4'd1: begin
                s16          = alu_a + alu_b;
                alu_result   = 32'(alu_a) + 32'(alu_b);
                alu_error[0] = (alu_a[15] == alu_b[15]) && (s16[15] != alu_a[15]);
            end
            4'd2: begin
                s16          = alu_a - alu_b;
                alu_result   = 32'(alu_a) - 32'(alu_b);
                alu_error[0] = (alu_a[15] != alu_b[15]) && (s16[15] != alu_a[15]);
            end
            4'd3: alu_result = 32'(alu_a) * 32'(alu_b);
            4'd4: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = 32'(alu_a / alu_b);
            4'd5: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = 32'(alu_a % alu_b);
            default: ;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for rsp_valid, check latency and operand stability in EXEC
    task automatic run_op(input string tag, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic ua, input logic [15:0] exp_a,
                          input int exp_lat);
        int   n;
        logic unstable;
        req_cmd     = c;
        req_a       = a;
        req_b       = b;
        req_use_acc = ua;
        req_valid   = 1'b1;
        tick;
        req_valid   = 1'b0;
        n        = 1;
        unstable = 1'b0;
        while (!rsp_valid && n < 40) begin
            if (alu_a !== exp_a || alu_b !== b || alu_cmd !== c) unstable = 1'b1;
            tick;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_exec_stable"}, 32'(unstable), 32'd0);
        check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
    endtask

    task automatic handshake(input logic clr);
        rsp_ready = 1'b1;
        sts_clr   = clr;
        tick;
        rsp_ready = 1'b0;
        sts_clr   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_cmd     = 4'd0;
        req_a       = 16'd0;
        req_b       = 16'd0;
        req_use_acc = 1'b0;
        rsp_ready   = 1'b0;
        sts_clr     = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_cmd", 32'(alu_cmd), 32'd0);
        check("rst_acc", acc, 32'd0);
        check("rst_sts", 32'(sts), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // Add 249+69
        run_op("add", 4'd1, 16'd249, 16'd69, 1'b0, 16'd249, 2);
        check("add_result", rsp_result, 32'd318);
        check("add_err", 32'(rsp_err), 32'd0);
        check("add_alu_cmd_resp", 32'(alu_cmd), 32'd0);
        handshake(1'b0);
        check("add_acc", acc, 32'd318);
        check("add_count", 32'(op_count), 32'd1);
        check("add_req_ready_after", 32'(req_ready), 32'd1);
        check("add_rsp_valid_after", 32'(rsp_valid), 32'd0);

        // Sub 249-69
        run_op("sub", 4'd2, 16'd249, 16'd69, 1'b0, 16'd249, 2);
        check("sub_result", rsp_result, 32'd180);
        check("sub_err", 32'(rsp_err), 32'd0);
        handshake(1'b0);
        check("sub_acc", acc, 32'd180);

        // Mul 249*69
        run_op("mul", 4'd3, 16'd249, 16'd69, 1'b0, 16'd249, 5);
        check("mul_result", rsp_result, 32'd17181);
        check("mul_err", 32'(rsp_err), 32'd0);
        handshake(1'b0);
        check("mul_acc", acc, 32'd17181);
        check("mul_count", 32'(op_count), 32'd3);

        // Divide by zero
        run_op("div0", 4'd4, 16'd100, 16'd0, 1'b0, 16'd100, 9);
        check("div0_result", rsp_result, 32'd0);
        check("div0_err", 32'(rsp_err), 32'b010);
        check("div0_alu_cmd_resp", 32'(alu_cmd), 32'd0);
        handshake(1'b0);
        check("div0_acc_unchanged", acc, 32'd17181);
        check("div0_sts", 32'(sts), 32'b010);
        check("div0_count", 32'(op_count), 32'd4);
        sts_clr = 1'b1;
        tick;
        sts_clr = 1'b0;
        check("sts_clr", 32'(sts), 32'd0);

        // Illegal opcode 7
        run_op("ill", 4'd7, 16'd1, 16'd2, 1'b0, 16'd100, 1);
        check("ill_result", rsp_result, 32'd0);
        check("ill_err", 32'(rsp_err), 32'b100);
        check("ill_alu_cmd", 32'(alu_cmd), 32'd0);
        check("ill_alu_a_held", 32'(alu_a), 32'd100);
        check("ill_alu_b_held", 32'(alu_b), 32'd0);
        handshake(1'b0);
        check("ill_count", 32'(op_count), 32'd5);
        check("ill_sts", 32'(sts), 32'b100);
        check("ill_acc_unchanged", acc, 32'd17181);

        // Chaining: 5+3, then acc+2 with backpressure
        run_op("chain1", 4'd1, 16'd5, 16'd3, 1'b0, 16'd5, 2);
        handshake(1'b0);
        check("chain1_acc", acc, 32'd8);
        run_op("chain2", 4'd1, 16'hFFFF, 16'd2, 1'b1, 16'd8, 2);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", rsp_result, 32'd10);
            check("bp_rsp_err", 32'(rsp_err), 32'd0);
        end
        check("bp_acc_not_yet", acc, 32'd8);
        handshake(1'b0);
        check("chain2_acc", acc, 32'd10);
        check("chain2_count", 32'(op_count), 32'd7);

        // Overflow on add, sts_clr coinciding with the handshake
        run_op("ovf", 4'd1, 16'd32000, 16'd16001, 1'b0, 16'd32000, 2);
        check("ovf_result", rsp_result, 32'd48001);
        check("ovf_err", 32'(rsp_err), 32'b001);
        handshake(1'b1);
        check("ovf_sts_clr_and_set", 32'(sts), 32'b001);
        check("ovf_acc_unchanged", acc, 32'd10);
        check("ovf_count", 32'(op_count), 32'd8);

        // Reset during the second EXEC cycle of a mul
        req_cmd     = 4'd3;
        req_a       = 16'd3;
        req_b       = 16'd4;
        req_use_acc = 1'b0;
        req_valid   = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_req_ready", 32'(req_ready), 32'd1);
        check("mrst_acc", acc, 32'd0);
        check("mrst_sts", 32'(sts), 32'd0);
        check("mrst_count", 32'(op_count), 32'd0);
        check("mrst_alu_cmd", 32'(alu_cmd), 32'd0);
        for (int i = 0; i < 5; i++) tick;
        check("mrst_no_late_rsp", 32'(rsp_valid), 32'd0);

        // Normal operation resumes after reset
        run_op("post", 4'd1, 16'd2, 16'd2, 1'b0, 16'd2, 2);
        check("post_result", rsp_result, 32'd4);
        handshake(1'b0);
        check("post_count", 32'(op_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
